// File: rtl/mcs4_pkg.sv
// MCS-4 fetch types: bus-cycle states, control request encoding, opcode constants.
// Pure declarations; no latency or flow control of its own.
package mcs4_pkg;

  typedef enum logic [3:0] {
    ST_A0, ST_A1, ST_A2, ST_A3, ST_M1, ST_M2, ST_X1, ST_X2, ST_X3
  } state_e;

  typedef enum logic [1:0] {
    CTL_NONE = 2'b00,
    CTL_JUMP = 2'b01,
    CTL_CALL = 2'b10,
    CTL_RET  = 2'b11
  } ctl_op_e;

  localparam logic [3:0] OPR_JCN     = 4'h1;
  localparam logic [3:0] OPR_FIM_SRC = 4'h2;
  localparam logic [3:0] OPR_JUN     = 4'h4;
  localparam logic [3:0] OPR_JMS     = 4'h5;
  localparam logic [3:0] OPR_ISZ     = 4'h7;
  localparam logic [3:0] OPR_IO      = 4'hE;

  // FIM shares OPR 2 with SRC; only the even OPA form carries a data word.
  function automatic logic is_two_word(input logic [3:0] opr, input logic [3:0] opa);
    return (opr == OPR_JCN) || (opr == OPR_JUN) || (opr == OPR_JMS) ||
           (opr == OPR_ISZ) || ((opr == OPR_FIM_SRC) && !opa[0]);
  endfunction

endpackage

// File: rtl/mcs4_pc_stack.sv
// PC stack: current level increments on inc_i, jump/call/ret applied on apply_i; one-clk update.
// MCS4_STACK_CHECK_EN adds sticky overflow/underflow flags; otherwise wrap is silent.
module mcs4_pc_stack
  import mcs4_pkg::*;
#(
  parameter int AW          = 12,
  parameter int STACK_DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          inc_i,
  input  logic          apply_i,
  input  ctl_op_e       op_i,
  input  logic [AW-1:0] addr_i,
  output logic [AW-1:0] pc_o,
  output logic          stack_ovf_o,
  output logic          stack_unf_o
);
  localparam int SPW = $clog2(STACK_DEPTH);
  localparam logic [SPW-1:0] SP_MAX = SPW'(STACK_DEPTH - 1);

  logic [AW-1:0]  lvl_q [STACK_DEPTH];
  logic [SPW-1:0] sp_q, sp_inc, sp_dec;

  assign sp_inc = (sp_q == SP_MAX) ? '0 : sp_q + 1'b1;
  assign sp_dec = (sp_q == '0) ? SP_MAX : sp_q - 1'b1;
  assign pc_o   = lvl_q[sp_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < STACK_DEPTH; i++) lvl_q[i] <= '0;
      sp_q <= '0;
    end else if (inc_i) begin
      lvl_q[sp_q] <= lvl_q[sp_q] + AW'(1);
    end else if (apply_i) begin
      case (op_i)
        CTL_JUMP: lvl_q[sp_q] <= addr_i;
        CTL_CALL: begin
          sp_q          <= sp_inc;
          lvl_q[sp_inc] <= addr_i;
        end
        CTL_RET:  sp_q <= sp_dec;
        default:  ;
      endcase
    end
  end

`ifdef MCS4_STACK_CHECK_EN
  // Depth starts at zero and wraps in step with sp, so sp itself is the depth count.
  logic ovf_q, unf_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (apply_i && !inc_i) begin
      if (op_i == CTL_CALL && sp_q == SP_MAX) ovf_q <= 1'b1;
      if (op_i == CTL_RET && sp_q == '0)      unf_q <= 1'b1;
    end
  end
  assign stack_ovf_o = ovf_q;
  assign stack_unf_o = unf_q;
`else
  assign stack_ovf_o = 1'b0;
  assign stack_unf_o = 1'b0;
`endif

endmodule

// File: rtl/mcs4_fetch_unit.sv
// MCS-4 A/M/X sequencer and opcode fetch; outputs move one clk after a PHI2 rising edge, no backpressure.
// Build option MCS4_STACK_CHECK_EN enables sticky stack overflow/underflow flags.
module mcs4_fetch_unit
  import mcs4_pkg::*;
#(
  parameter int ADDR_NIBBLES = 3,
  parameter int STACK_DEPTH  = 4,
  parameter int RAM_BANKS    = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      phi2_i,
  input  logic [3:0]                d_i,
  output logic [3:0]                d_o,
  output logic                      d_oe_o,
  output logic                      sync_o,
  output logic                      cm_rom_o,
  output logic [RAM_BANKS-1:0]      cm_ram_o,
  input  logic [2:0]                bank_sel_i,
  output logic                      instr_valid_o,
  output logic [3:0]                opr_o,
  output logic [3:0]                opa_o,
  output logic [7:0]                word2_o,
  output logic                      two_word_o,
  output logic [4*ADDR_NIBBLES-1:0] pc_o,
  input  logic                      ctl_valid_i,
  input  logic [1:0]                ctl_op_i,
  input  logic [4*ADDR_NIBBLES-1:0] ctl_addr_i,
  output logic                      stack_ovf_o,
  output logic                      stack_unf_o
);
  localparam int AW = 4 * ADDR_NIBBLES;
  localparam state_e LAST_A = state_e'(4'(ADDR_NIBBLES - 1));

  state_e               state_q, state_d;
  logic                 phi2_q, edge_w, leave_m1, leave_m2, apply_w, in_x, cm_on;
  logic [3:0]           hi_q, fw_opr_q, fw_opa_q, opr_q, opa_q;
  logic [7:0]           word2_q;
  logic                 wait_w2_q, src_q, instr_valid_q, two_word_q, cm_rom_q;
  logic [RAM_BANKS-1:0] cm_ram_q, bank_mask;
  ctl_op_e              ctl_op_q, ctl_op_w;
  logic [AW-1:0]        ctl_addr_q, ctl_addr_w, pc_w;

  assign edge_w   = phi2_i & ~phi2_q;
  assign leave_m1 = edge_w && (state_q == ST_M1);
  assign leave_m2 = edge_w && (state_q == ST_M2);
  assign apply_w  = edge_w && (state_q == ST_X3);
  assign in_x     = (state_q == ST_X1) || (state_q == ST_X2) || (state_q == ST_X3);

  // A request arriving on the applying clk still counts as the latest one.
  assign ctl_op_w   = (ctl_valid_i && in_x) ? ctl_op_e'(ctl_op_i) : ctl_op_q;
  assign ctl_addr_w = (ctl_valid_i && in_x) ? ctl_addr_i : ctl_addr_q;

  always_comb begin
    state_d = state_q;
    if (edge_w) begin
      case (state_q)
        ST_M1:   state_d = ST_M2;
        ST_M2:   state_d = ST_X1;
        ST_X1:   state_d = ST_X2;
        ST_X2:   state_d = ST_X3;
        ST_X3:   state_d = ST_A0;
        default: state_d = (state_q == LAST_A) ? ST_M1 : state_e'(4'(state_q) + 4'd1);
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < RAM_BANKS; i++) bank_mask[i] = (int'(bank_sel_i) != i);
  end

  assign cm_on = edge_w && ((state_d == LAST_A) ||
                            (leave_m1 && !wait_w2_q && d_i == OPR_IO) ||
                            (state_q == ST_X1 && src_q));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phi2_q        <= 1'b0;
      state_q       <= ST_X3;
      hi_q          <= '0;
      fw_opr_q      <= '0;
      fw_opa_q      <= '0;
      wait_w2_q     <= 1'b0;
      src_q         <= 1'b0;
      ctl_op_q      <= CTL_NONE;
      ctl_addr_q    <= '0;
      cm_rom_q      <= 1'b1;
      cm_ram_q      <= '1;
      instr_valid_q <= 1'b0;
      opr_q         <= '0;
      opa_q         <= '0;
      word2_q       <= '0;
      two_word_q    <= 1'b0;
    end else begin
      phi2_q        <= phi2_i;
      state_q       <= state_d;
      instr_valid_q <= 1'b0;
      if (ctl_valid_i && in_x) begin
        ctl_op_q   <= ctl_op_e'(ctl_op_i);
        ctl_addr_q <= ctl_addr_i;
      end
      if (apply_w) ctl_op_q <= CTL_NONE;
      if (leave_m1) hi_q <= d_i;
      if (leave_m2) begin
        if (wait_w2_q) begin
          instr_valid_q <= 1'b1;
          opr_q         <= fw_opr_q;
          opa_q         <= fw_opa_q;
          word2_q       <= {hi_q, d_i};
          two_word_q    <= 1'b1;
          wait_w2_q     <= 1'b0;
          src_q         <= 1'b0;
        end else if (is_two_word(hi_q, d_i)) begin
          fw_opr_q  <= hi_q;
          fw_opa_q  <= d_i;
          wait_w2_q <= 1'b1;
          src_q     <= 1'b0;
        end else begin
          instr_valid_q <= 1'b1;
          opr_q         <= hi_q;
          opa_q         <= d_i;
          word2_q       <= '0;
          two_word_q    <= 1'b0;
          src_q         <= (hi_q == OPR_FIM_SRC) && d_i[0];
        end
      end
      if (edge_w) begin
        cm_rom_q <= ~cm_on;
        cm_ram_q <= cm_on ? bank_mask : '1;
      end
    end
  end

  always_comb begin
    d_o = 4'h0;
    for (int k = 0; k < ADDR_NIBBLES; k++) begin
      if (state_q == state_e'(4'(k))) d_o = pc_w[4*k +: 4];
    end
  end

  assign d_oe_o        = (state_q <= LAST_A);
  assign sync_o        = (state_q != ST_X3);
  assign cm_rom_o      = cm_rom_q;
  assign cm_ram_o      = cm_ram_q;
  assign instr_valid_o = instr_valid_q;
  assign opr_o         = opr_q;
  assign opa_o         = opa_q;
  assign word2_o       = word2_q;
  assign two_word_o    = two_word_q;
  assign pc_o          = pc_w;

  mcs4_pc_stack #(
    .AW          (AW),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_pc_stack (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .inc_i       (leave_m2),
    .apply_i     (apply_w),
    .op_i        (ctl_op_w),
    .addr_i      (ctl_addr_w),
    .pc_o        (pc_w),
    .stack_ovf_o (stack_ovf_o),
    .stack_unf_o (stack_unf_o)
  );

endmodule

// File: tb/tb_mcs4_fetch_unit.sv
// Bench for mcs4_fetch_unit: directed program scenarios then random programs and control requests,
// all compared per PHI2 edge against an instruction-level model of fetch and PC stack.
module tb_mcs4_fetch_unit;
  localparam int N = 3, D = 4, RB = 4;
`ifdef MCS4_STACK_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, phi2, ctl_valid;
  logic [3:0] d_in, d_out, opr, opa;
  logic [1:0] ctl_op;
  logic [11:0] ctl_addr, pc;
  logic [2:0] bank;
  logic d_oe, sync, cm_rom, ivld, two, ovf_o, unf_o;
  logic [RB-1:0] cm_ram;
  logic [7:0] w2;

  mcs4_fetch_unit #(.ADDR_NIBBLES(N), .STACK_DEPTH(D), .RAM_BANKS(RB)) dut (
    .clk_i(clk), .rst_ni(rst_n), .phi2_i(phi2), .d_i(d_in), .d_o(d_out), .d_oe_o(d_oe),
    .sync_o(sync), .cm_rom_o(cm_rom), .cm_ram_o(cm_ram), .bank_sel_i(bank),
    .instr_valid_o(ivld), .opr_o(opr), .opa_o(opa), .word2_o(w2), .two_word_o(two),
    .pc_o(pc), .ctl_valid_i(ctl_valid), .ctl_op_i(ctl_op), .ctl_addr_i(ctl_addr),
    .stack_ovf_o(ovf_o), .stack_unf_o(unf_o));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, pulses = 0;
  always @(posedge clk) if (ivld === 1'b1) pulses++;

  // Reference model: instruction-level view of one bus cycle per phase index 0..N+4.
  logic [7:0]  rom [4096];
  logic [11:0] stk [D];
  int sp, depth, ph, e_pulse;
  bit ovf, unf, wait2, src, e_cm, e_two;
  logic [7:0] first, e_w2;
  logic [3:0] e_opr, e_opa;
  logic [1:0] pend;
  logic [11:0] pend_a;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) stk[i] = '0;
    sp = 0; depth = 0; ovf = 0; unf = 0; wait2 = 0; src = 0; ph = N + 4;
    pend = 0; pend_a = 0; e_opr = 0; e_opa = 0; e_w2 = 0; e_two = 0;
  endtask

  task automatic model_step();
    logic [7:0] b;
    int p = ph;
    e_pulse = 0; e_cm = 0;
    b = rom[stk[sp]];
    if (p < N) ph = p + 1;
    else if (p == N) begin
      e_cm = !wait2 && (b[7:4] == 4'hE);
      ph = N + 1;
    end else if (p == N + 1) begin
      stk[sp] = stk[sp] + 12'd1;
      if (wait2) begin
        e_opr = first[7:4]; e_opa = first[3:0]; e_w2 = b; e_two = 1; e_pulse = 1;
        wait2 = 0; src = 0;
      end else if ((b[7:4] inside {4'h1, 4'h4, 4'h5, 4'h7}) || (b[7:4] == 4'h2 && !b[0])) begin
        first = b; wait2 = 1; src = 0;
      end else begin
        e_opr = b[7:4]; e_opa = b[3:0]; e_w2 = 0; e_two = 0; e_pulse = 1;
        src = (b[7:4] == 4'h2) && b[0];
      end
      ph = N + 2;
    end else if (p == N + 2) begin
      e_cm = src; ph = N + 3;
    end else if (p == N + 3) ph = N + 4;
    else begin
      case (pend)
        2'd1: stk[sp] = pend_a;
        2'd2: begin
          sp = (sp + 1) % D; stk[sp] = pend_a;
          if (depth == D - 1) begin depth = 0; ovf = 1; end else depth++;
        end
        2'd3: begin
          sp = (sp + D - 1) % D;
          if (depth == 0) begin depth = D - 1; unf = 1; end else depth--;
        end
        default: ;
      endcase
      pend = 0; ph = 0;
    end
    if (ph == N - 1) e_cm = 1;
  endtask

  task automatic check_outputs();
    logic [11:0] sh;
    logic [RB-1:0] r;
    sh = stk[sp] >> (4 * ph);
    r = '1;
    if (e_cm && bank < RB) r[bank] = 1'b0;
    check_eq("sync", sync, ph != N + 4);
    check_eq("d_oe", d_oe, ph < N);
    check_eq("d_o", d_out, (ph < N) ? sh[3:0] : 4'h0);
    check_eq("cm_rom", cm_rom, !e_cm);
    check_eq("cm_ram", cm_ram, r);
    check_eq("pc", pc, stk[sp]);
    check_eq("instr_valid", pulses, e_pulse);
    check_eq("opr", opr, e_opr);
    check_eq("opa", opa, e_opa);
    check_eq("word2", w2, e_w2);
    check_eq("two_word", two, e_two);
    check_eq("stack_ovf", ovf_o, CHK && ovf);
    check_eq("stack_unf", unf_o, CHK && unf);
  endtask

  task automatic check_reset();
    check_eq("rst_sync", sync, 0);
    check_eq("rst_cm_rom", cm_rom, 1);
    check_eq("rst_cm_ram", cm_ram, {RB{1'b1}});
    check_eq("rst_d_o", d_out, 0);
    check_eq("rst_d_oe", d_oe, 0);
    check_eq("rst_pc", pc, 0);
    check_eq("rst_valid", ivld, 0);
    check_eq("rst_decode", {opr, opa, w2, two}, 0);
    check_eq("rst_flags", {ovf_o, unf_o}, 0);
  endtask

  task automatic phi2_edge();
    pulses = 0;
    phi2 = 1'b1;
    repeat (3) @(negedge clk);
    phi2 = 1'b0;
    repeat (3) @(negedge clk);
    model_step();
    if (ph == N) d_in = rom[stk[sp]][7:4];
    else if (ph == N + 1) d_in = rom[stk[sp]][3:0];
    else d_in = 4'($urandom);
    check_outputs();
  endtask

  task automatic ctl_pulse(input int op, input logic [11:0] a);
    ctl_valid = 1'b1; ctl_op = op[1:0]; ctl_addr = a;
    if (ph >= N + 2) begin pend = op[1:0]; pend_a = a; end
    @(negedge clk);
    ctl_valid = 1'b0; ctl_op = 2'($urandom); ctl_addr = 12'($urandom);
  endtask

  task automatic run_cycle(input int op, input logic [11:0] a = 12'h0,
                           input int op2 = -1, input logic [11:0] a2 = 12'h0, input int ign = -1);
    for (int e = 0; e < N + 5; e++) begin
      phi2_edge();
      if (ph == N + 2 && op >= 0) ctl_pulse(op, a);
      if (ph == N + 3 && op2 >= 0) ctl_pulse(op2, a2);
      if (ph == 1 && ign >= 0) ctl_pulse(ign, 12'($urandom));
    end
  endtask

  initial begin
    rst_n = 1'b0; phi2 = 1'b0; d_in = 4'h0; ctl_valid = 1'b0; ctl_op = 2'd0;
    ctl_addr = 12'h0; bank = 3'd0;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[0] = 8'hD5; rom[1] = 8'hF0; rom[2] = 8'h40; rom[3] = 8'h23;
    rom[12'h400] = 8'hE0; rom[12'h401] = 8'h21;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    @(negedge clk);

    run_cycle(-1);                      // D5 at 0
    run_cycle(-1);                      // F0 at 1
    run_cycle(-1);                      // JUN first word
    run_cycle(1, 12'h123);              // word2 0x23, jump
    run_cycle(1, 12'h004, -1, 12'h0, 2); // ignored CALL in A1
    run_cycle(2, 12'h200);              // CALL at PC 5
    run_cycle(3);                       // RET back to 5
    for (int i = 0; i < 4; i++) run_cycle(2, 12'h300 + 12'(i));
    run_cycle(3);                       // RET with wrapped depth
    bank = 3'd2;
    run_cycle(1, 12'h400);
    run_cycle(-1);                      // E0: RAM bank 2 in A2 and M2
    run_cycle(-1);                      // SRC: CM in X2

    for (int e = 0; e < N + 1; e++) phi2_edge();
    rst_n = 1'b0;
    #2;
    check_reset();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_cycle(-1);

    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    for (int c = 0; c < 150; c++) begin
      int op, op2, ign;
      bank = 3'($urandom_range(0, 7));
      op  = ($urandom_range(0, 9) < 4) ? -1 : int'($urandom_range(0, 3));
      op2 = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
      ign = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : -1;
      run_cycle(op, 12'($urandom), op2, 12'($urandom), ign);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
